// File: rtl/pipe_draw_scheduler.sv
// Per-frame pipe sequencer: erases last frame's pipes, then draws the current ones,
// driving the single pipe drawer once per valid slot.
module pipe_draw_scheduler #(
  parameter int unsigned NUM_PIPES = 3,
  parameter int unsigned COORD_W   = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [NUM_PIPES*COORD_W-1:0] pipe_xs,
  input  logic [NUM_PIPES*COORD_W-1:0] pipe_ys,
  input  logic [NUM_PIPES-1:0]         pipe_valid,
  output logic                         drv_enable,
  input  logic                         drv_done,
  output logic [COORD_W-1:0]           drv_x,
  output logic [COORD_W-1:0]           drv_y,
  output logic                         pixel_color,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int unsigned BUS_W = NUM_PIPES * COORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIPES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE_SEL, S_ERASE_RUN, S_DRAW_SEL, S_DRAW_RUN, S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [BUS_W-1:0]      r_cur_xs, r_cur_ys, r_prev_xs, r_prev_ys;
  logic [NUM_PIPES-1:0]  r_cur_valid, r_prev_valid;
  logic [COORD_W-1:0]    r_drv_x, r_drv_y, w_drv_x_nxt, w_drv_y_nxt;
  logic                  r_color, w_color_nxt;
  logic                  w_snap, w_commit;
  logic [31:0]           w_off;
  logic                  w_last;

  assign w_off  = 32'(r_idx) * 32'(COORD_W);
  assign w_last = (r_idx == LAST_IDX);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cur_xs     <= '0;
      r_cur_ys     <= '0;
      r_cur_valid  <= '0;
      r_prev_xs    <= '0;
      r_prev_ys    <= '0;
      r_prev_valid <= '0;
      r_drv_x      <= '0;
      r_drv_y      <= '0;
      r_color      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_drv_x <= w_drv_x_nxt;
      r_drv_y <= w_drv_y_nxt;
      r_color <= w_color_nxt;
      if (w_snap) begin
        r_cur_xs    <= pipe_xs;
        r_cur_ys    <= pipe_ys;
        r_cur_valid <= pipe_valid;
      end
      if (w_commit) begin
        r_prev_xs    <= r_cur_xs;
        r_prev_ys    <= r_cur_ys;
        r_prev_valid <= r_cur_valid;
      end
    end
  end

  // Next-state and slot selection
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_drv_x_nxt = r_drv_x;
    w_drv_y_nxt = r_drv_y;
    w_color_nxt = r_color;
    w_snap      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_snap      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_ERASE_SEL;
        end
      end
      S_ERASE_SEL: begin
        if (r_prev_valid[r_idx]) begin
          w_drv_x_nxt = r_prev_xs[w_off +: COORD_W];
          w_drv_y_nxt = r_prev_ys[w_off +: COORD_W];
          w_color_nxt = 1'b0;
          w_state_nxt = S_ERASE_RUN;
        end else if (w_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_DRAW_SEL;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_ERASE_RUN: begin
        if (drv_done) begin
          if (w_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_DRAW_SEL;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_ERASE_SEL;
          end
        end
      end
      S_DRAW_SEL: begin
        if (r_cur_valid[r_idx]) begin
          w_drv_x_nxt = r_cur_xs[w_off +: COORD_W];
          w_drv_y_nxt = r_cur_ys[w_off +: COORD_W];
          w_color_nxt = 1'b1;
          w_state_nxt = S_DRAW_RUN;
        end else if (w_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_DRAW_RUN: begin
        if (drv_done) begin
          if (w_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_DRAW_SEL;
          end
        end
      end
      S_DONE: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Enable drops the cycle after drv_done so the drawer does not restart
  assign drv_enable  = (r_state == S_ERASE_RUN) || (r_state == S_DRAW_RUN);
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = (r_state == S_DONE);
  assign drv_x       = r_drv_x;
  assign drv_y       = r_drv_y;
  assign pixel_color = r_color;

endmodule

// File: doc/pipe_draw_scheduler.md
# pipe_draw_scheduler

Per-frame sequencer for the single `pipe_drawer` instance, which draws one pipe outline at a time. On each frame tick it erases the previous frame's pipes (color 0) at their old coordinates, then draws the current pipes (color 1). Each pass drives the drawer once per valid pipe slot. It sits between the game-state logic (pipe positions) and the drawer/framebuffer write path; `pixel_color` accompanies the drawer's x/y into the framebuffer.

## Interface
- `NUM_PIPES`, default 3: number of pipe slots.
- `COORD_W`, default 11: coordinate width; must match the drawer.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `frame_start`  in  1: frame tick; starts a sequence if sampled high in IDLE.
- `pipe_xs`  in  NUM_PIPES*COORD_W: slot i center x at `[COORD_W*i +: COORD_W]`.
- `pipe_ys`  in  NUM_PIPES*COORD_W: slot i gap y, same packing.
- `pipe_valid`  in  NUM_PIPES: slot i active.
- `drv_enable`  out  1: drawer enable.
- `drv_done`  in  1: drawer done; a one-cycle pulse on its last pixel.
- `drv_x`, `drv_y`  out  COORD_W: to drawer `pipe_x`/`pipe_y`.
- `pixel_color`  out  1: 0 = erase, 1 = draw.
- `busy`  out  1: high whenever state is not IDLE.
- `frame_done`  out  1: one-cycle pulse when the sequence finishes.

## Operation
- State machine: IDLE, ERASE_SEL, ERASE_RUN, DRAW_SEL, DRAW_RUN, DONE.
- **IDLE**
  - If `frame_start` is high, snapshot `pipe_xs`/`pipe_ys`/`pipe_valid` into cur registers.
  - Set idx to 0 and go to ERASE_SEL.
  - Inputs are ignored at all other times, including `frame_start` while busy.
- **ERASE_SEL**, one cycle per slot:
  - If `prev_valid[idx]`, load `drv_x`/`drv_y` from prev coords, set `pixel_color` to 0, go to ERASE_RUN.
  - Otherwise, if idx equals NUM_PIPES-1, set idx to 0 and go to DRAW_SEL; else increment idx.
- **ERASE_RUN**
  - `drv_enable` is 1.
  - On `drv_done`: if idx equals NUM_PIPES-1, set idx to 0 and go to DRAW_SEL; else increment idx and go to ERASE_SEL.
- **DRAW_SEL / DRAW_RUN**
  - Same as the erase pass, using cur valid/coords with `pixel_color` 1.
  - After the last slot, go to DONE.
- **DONE**
  - `frame_done` is 1 for one cycle.
  - Copy cur into prev (valid and coords).
  - Go to IDLE.
- `drv_enable` is decoded combinationally from the registered state (high in *_RUN only). It therefore falls in the cycle right after `drv_done` is sampled, so the drawer sees enable low on returning to idle and does not restart.
- `drv_x`/`drv_y`/`pixel_color` are registered and held constant for the whole RUN state. The drawer samples its coordinates continuously, so they must not change mid-draw.
- No valid slots in either pass: the sequence is 2*NUM_PIPES SEL cycles plus DONE, and `drv_enable` never rises.
- A `drv_done` arriving outside *_RUN is ignored.

## Timing
- Reset values: state IDLE, idx 0, `prev_valid` 0, cur/prev coords 0, `drv_x`/`drv_y` 0, `pixel_color` 0, `drv_enable` 0, `busy` 0, `frame_done` 0.
- Start: `frame_start` sampled at edge 0 → `busy` goes to 1 after edge 0.
- Each SEL visit takes one cycle. `drv_enable` rises one cycle after the SEL cycle that selects a slot.
- RUN lasts until `drv_done` is sampled. The next SEL begins on the edge that samples it.
- Total sequence length = 2*NUM_PIPES SEL cycles + sum of drawer run lengths + 1 DONE cycle.
- A `frame_start` coincident with DONE is ignored, because state is not IDLE at that edge.
- Reset mid-sequence:
  - State goes to IDLE at the next edge; `drv_enable` goes low.
  - `prev_valid` clears, so the next frame performs no erase.
  - The drawer must be reset by the same signal.

## Test plan
Use a stub drawer that asserts `drv_done` for 1 cycle, 5 cycles after enable is first seen.
- First frame after reset: valid=3'b101, x={100,250,400}, y={380,300,200} → no erase runs. Two draw runs with (100,380) then (400,200), color 1. `frame_done` pulses; total 2*3+2*6+1 cycles.
- Second frame: valid=3'b010, x[1]=240 → erase runs at (100,380) and (400,200) with color 0, then a draw run at (240,300) with color 1.
- Inputs change and `frame_start` pulses during RUN → ignored: `drv_x`/`drv_y` stay stable and no restart occurs.
- All slots invalid twice in a row → `frame_done` arrives 7 cycles after the second `frame_start`; `drv_enable` stays 0 throughout.
- Reset asserted during DRAW_RUN → IDLE next cycle with all outputs at reset values. The next frame, valid=3'b001, issues no erase runs.
- Enable handshake: `drv_enable` is 0 in the cycle after `drv_done`. Use the real drawer at x=100, y=380 to confirm it draws exactly once.
